// File: rtl/ast_mx_pkg.sv
// Shared types and helpers for the Avalon-ST packet multiplexer.
// Combinational only; no latency or backpressure of its own.
package ast_mx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ast_mx_state_t;

    // Index of the candidate 'offset' places after 'last' in round-robin order.
    function automatic int rr_index(input int last, input int offset, input int n);
        return (last + 1 + offset) % n;
    endfunction

endpackage

// File: rtl/ast_mx_if.sv
// Bundle of the TX_DIR input streams and the merged output stream.
// Wires only: no latency; ready/valid carried straight through.
interface ast_mx_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
    parameter int TX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = $clog2(TX_DIR)
);
    logic [TX_DIR-1:0][DATA_WIDTH-1:0]    ast_data_i;
    logic [TX_DIR-1:0]                    ast_startofpacket_i;
    logic [TX_DIR-1:0]                    ast_endofpacket_i;
    logic [TX_DIR-1:0]                    ast_valid_i;
    logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]   ast_empty_i;
    logic [TX_DIR-1:0][CHANNEL_WIDTH-1:0] ast_channel_i;
    logic [TX_DIR-1:0]                    ast_ready_o;
    logic [DATA_WIDTH-1:0]                ast_data_o;
    logic                                 ast_startofpacket_o;
    logic                                 ast_endofpacket_o;
    logic                                 ast_valid_o;
    logic [EMPTY_WIDTH-1:0]               ast_empty_o;
    logic [CHANNEL_WIDTH-1:0]             ast_channel_o;
    logic [DIR_SEL_WIDTH-1:0]             ast_dir_o;
    logic                                 ast_ready_i;

    modport slave (
        input  ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
        input  ast_empty_i, ast_channel_i, ast_ready_i,
        output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
        output ast_valid_o, ast_empty_o, ast_channel_o, ast_dir_o
    );

    modport master (
        output ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
        output ast_empty_i, ast_channel_i, ast_ready_i,
        input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
        input  ast_valid_o, ast_empty_o, ast_channel_o, ast_dir_o
    );

endinterface

// File: rtl/ast_rr_arbiter.sv
// Round-robin pick of the first requester after 'last'; combinational, zero latency.
// No backpressure: the caller decides whether the grant is used.
module ast_rr_arbiter
    import ast_mx_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'(rr_index(int'(last_i), i, N));
            if (!gnt_vld_o && req_i[cand]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/ast_mx.sv
// Merges TX_DIR Avalon-ST inputs into one stream with packet-level round-robin; registered output, 1 clk latency.
// Backpressure: a stalled output register drops every input ready; only the selected input ever sees ready.
module ast_mx
    import ast_mx_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
    parameter int TX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = $clog2(TX_DIR)
) (
    input  logic     clk_i,
    input  logic     rst_i,
    ast_mx_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_BUSY = 1'(BUSY);

    logic [0:0]               state_q, state_d;
    logic [DIR_SEL_WIDTH-1:0] last_q, last_d;
    logic                     valid_q, valid_d;
    logic                     sop_q, sop_d;
    logic                     eop_q, eop_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [EMPTY_WIDTH-1:0]   empty_q, empty_d;
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
    logic [DIR_SEL_WIDTH-1:0] dir_q, dir_d;

    logic [TX_DIR-1:0]        req;
    logic [TX_DIR-1:0]        ready;
    logic [DIR_SEL_WIDTH-1:0] arb_idx;
    logic [DIR_SEL_WIDTH-1:0] sel;
    logic                     arb_vld;
    logic                     sel_ok;
    logic                     load_en;
    logic                     take;

    // Only SOP beats may open a packet; in BUSY the arbiter is ignored.
    assign req = (state_q == ST_IDLE) ? (bus.ast_valid_i & bus.ast_startofpacket_i) : '0;

    ast_rr_arbiter #(.N(TX_DIR)) u_arb (
        .req_i     (req),
        .last_i    (last_q),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    always_comb begin
        load_en = !valid_q || bus.ast_ready_i;
        sel     = (state_q == ST_BUSY) ? last_q : arb_idx;
        sel_ok  = !rst_i && ((state_q == ST_BUSY) || arb_vld);
        ready   = '0;
        if (load_en && sel_ok) ready[sel] = 1'b1;
        take    = load_en && sel_ok && bus.ast_valid_i[sel];
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;
        empty_d = empty_q;
        chan_d  = chan_q;
        dir_d   = dir_q;
        if (take) begin
            valid_d = 1'b1;
            sop_d   = bus.ast_startofpacket_i[sel];
            eop_d   = bus.ast_endofpacket_i[sel];
            data_d  = bus.ast_data_i[sel];
            empty_d = bus.ast_empty_i[sel];
            chan_d  = bus.ast_channel_i[sel];
            dir_d   = sel;
            if (state_q == ST_IDLE) begin
                last_d = sel;
                if (!bus.ast_endofpacket_i[sel]) state_d = ST_BUSY;
            end else if (bus.ast_endofpacket_i[sel]) begin
                state_d = ST_IDLE;
            end
        end else if (bus.ast_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= DIR_SEL_WIDTH'(TX_DIR - 1);
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            empty_q <= '0;
            chan_q  <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
            empty_q <= empty_d;
            chan_q  <= chan_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.ast_ready_o         = ready;
    assign bus.ast_valid_o         = valid_q;
    assign bus.ast_startofpacket_o = sop_q;
    assign bus.ast_endofpacket_o   = eop_q;
    assign bus.ast_data_o          = data_q;
    assign bus.ast_empty_o         = empty_q;
    assign bus.ast_channel_o       = chan_q;
    assign bus.ast_dir_o           = dir_q;

endmodule

// File: tb/tb_ast_mx.sv
// Directed bench for ast_mx: reset, single beat, round-robin order, stalls, fairness, async reset.
module tb_ast_mx;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [7:0]  ch;
        logic [1:0]  dir;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    failures = 0;
    bit    rnd_rdy = 1'b0;
    beat_t src_q [4][$];
    beat_t out_q [$];
    beat_t exp_q [$];

    ast_mx_if bus ();

    ast_mx dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk(input int lane, input logic [63:0] data, input logic sop,
                                 input logic eop, input logic [2:0] empty, input logic [7:0] ch);
        beat_t b;
        b.data  = data;
        b.sop   = sop;
        b.eop   = eop;
        b.empty = empty;
        b.ch    = ch;
        b.dir   = 2'(lane);
        return b;
    endfunction

    function automatic beat_t cur_out();
        return mk(int'(bus.ast_dir_o), bus.ast_data_o, bus.ast_startofpacket_o,
                  bus.ast_endofpacket_o, bus.ast_empty_o, bus.ast_channel_o);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int lane, input int n, input logic [63:0] base);
        for (int b = 0; b < n; b++)
            src_q[lane].push_back(mk(lane, base + 64'(b), b == 0, b == n - 1,
                                     3'(b), 8'(lane * 16 + b)));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick();
        beat_t      b;
        beat_t      snap;
        logic [3:0] acc;
        logic       stall;
        for (int k = 0; k < 4; k++) begin
            b = (src_q[k].size() > 0) ? src_q[k][0] : '0;
            bus.ast_valid_i[k]         = src_q[k].size() > 0;
            bus.ast_data_i[k]          = b.data;
            bus.ast_startofpacket_i[k] = b.sop;
            bus.ast_endofpacket_i[k]   = b.eop;
            bus.ast_empty_i[k]         = b.empty;
            bus.ast_channel_i[k]       = b.ch;
        end
        bus.ast_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        acc   = bus.ast_valid_i & bus.ast_ready_o;
        stall = bus.ast_valid_o && !bus.ast_ready_i;
        snap  = cur_out();
        if (bus.ast_valid_o && bus.ast_ready_i) out_q.push_back(snap);
        if (stall) chk("stall_ready", 128'(bus.ast_ready_o), 128'(0));
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (acc[k]) void'(src_q[k].pop_front());
        if (stall) chk("stall_hold", 128'({bus.ast_valid_o, cur_out()}), 128'({1'b1, snap}));
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0
                || bus.ast_valid_o) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 128'(n >= budget), 128'(0));
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, 128'(out_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 128'(out_q[i]), 128'(exp_q[i]));
    endtask

    initial begin
        int idx3;
        bus.ast_data_i          = '0;
        bus.ast_startofpacket_i = '0;
        bus.ast_endofpacket_i   = '0;
        bus.ast_valid_i         = '0;
        bus.ast_empty_i         = '0;
        bus.ast_channel_i       = '0;
        bus.ast_ready_i         = 1'b1;

        // Reset: a pending SOP on input 0 must still see ready low.
        rst = 1'b1;
        bus.ast_valid_i[0]         = 1'b1;
        bus.ast_startofpacket_i[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(bus.ast_valid_o), 128'(0));
        chk("rst_ready", 128'(bus.ast_ready_o), 128'(0));
        chk("rst_out", 128'(cur_out()), 128'(0));
        rst = 1'b0;
        bus.ast_valid_i = '0;
        @(negedge clk);

        // 1: single-beat packet from input 0.
        src_q[0].push_back(mk(0, 64'hA5, 1'b1, 1'b1, 3'd3, 8'd7));
        tick();
        chk("t1_out", 128'({bus.ast_valid_o, cur_out()}),
            128'({1'b1, mk(0, 64'hA5, 1'b1, 1'b1, 3'd3, 8'd7)}));
        tick();
        chk("t1_valid_drop", 128'(bus.ast_valid_o), 128'(0));

        // 2: all four inputs at once; last grant is 0, so order is 1,2,3,0.
        out_q.delete(); exp_q.delete();
        for (int l = 0; l < 4; l++) push_pkt(l, 3, 64'h200 + 64'(l * 16));
        for (int j = 1; j <= 4; j++)
            for (int b = 0; b < 3; b++)
                exp_q.push_back(mk(j % 4, 64'h200 + 64'((j % 4) * 16 + b), b == 0, b == 2,
                                   3'(b), 8'((j % 4) * 16 + b)));
        drain(200);
        cmp_q("t2");

        // 3: five beats from input 2 under random downstream stalls.
        out_q.delete(); exp_q.delete();
        rnd_rdy = 1'b1;
        push_pkt(2, 5, 64'h300);
        for (int b = 0; b < 5; b++)
            exp_q.push_back(mk(2, 64'h300 + 64'(b), b == 0, b == 4, 3'(b), 8'(32 + b)));
        drain(400);
        rnd_rdy = 1'b0;
        cmp_q("t3");

        // 4: input 1 streams one-beat packets; input 3 joins after two grants.
        out_q.delete(); exp_q.delete();
        for (int i = 0; i < 10; i++) push_pkt(1, 1, 64'h400 + 64'(i * 16));
        tick();
        tick();
        push_pkt(3, 1, 64'h4F0);
        for (int i = 0; i < 2; i++) exp_q.push_back(mk(1, 64'h400 + 64'(i * 16), 1'b1, 1'b1, 3'd0, 8'd16));
        exp_q.push_back(mk(3, 64'h4F0, 1'b1, 1'b1, 3'd0, 8'd48));
        for (int i = 2; i < 10; i++) exp_q.push_back(mk(1, 64'h400 + 64'(i * 16), 1'b1, 1'b1, 3'd0, 8'd16));
        drain(200);
        idx3 = 99;
        for (int i = out_q.size() - 1; i >= 0; i--)
            if (out_q[i].dir == 2'd3) idx3 = i;
        chk("t4_fair_within_2", 128'(idx3 <= 4), 128'(1));
        cmp_q("t4");

        // 5: async reset in the middle of a 4-beat packet.
        out_q.delete(); exp_q.delete();
        push_pkt(0, 4, 64'h500);
        tick();
        tick();
        chk("t5_valid_before", 128'(bus.ast_valid_o), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 128'(bus.ast_valid_o), 128'(0));
        chk("t5_async_ready", 128'(bus.ast_ready_o), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) src_q[k].delete();
        out_q.delete();
        push_pkt(2, 2, 64'h600);
        push_pkt(0, 2, 64'h610);
        for (int b = 0; b < 2; b++) exp_q.push_back(mk(0, 64'h610 + 64'(b), b == 0, b == 1, 3'(b), 8'(b)));
        for (int b = 0; b < 2; b++) exp_q.push_back(mk(2, 64'h600 + 64'(b), b == 0, b == 1, 3'(b), 8'(32 + b)));
        drain(200);
        cmp_q("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
